// File: rtl/regfile_scb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scb
// Purpose  : Register file with a per-register pending-write scoreboard.
//            Define REGFILE_BYPASS_EN for write-through forwarding on reads.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scb #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              hazA,
    output logic              hazB,
    input  logic [ADDR_W-1:0] dstA,
    input  logic [ADDR_W-1:0] dstB,
    input  logic [DATA_W-1:0] dstA_data,
    input  logic [DATA_W-1:0] dstB_data,
    input  logic [ADDR_W-1:0] issA,
    input  logic [ADDR_W-1:0] issB,
    output logic              iss_ready_o,
    output logic              err_o
);
    localparam int                c_NREG  = (1 << ADDR_W) - 1;
    localparam int                c_SW    = CNT_W + 2;
    localparam logic [ADDR_W-1:0] c_RNONE = '1;

    logic [DATA_W-1:0]      r_mem [c_NREG];
    logic [CNT_W-1:0]       r_cnt [c_NREG];
    logic                   r_err;
    logic signed [c_SW-1:0] w_sum [c_NREG];
    logic [c_NREG-1:0]      w_ovf;
    logic [c_NREG-1:0]      w_unf;

    // Net pending count per register; only an issued register can exceed the maximum.
    always_comb begin
        w_sum = '{default: '0};
        w_ovf = '0;
        w_unf = '0;
        for (int r = 0; r < c_NREG; r++) begin
            w_sum[r] = c_SW'(r_cnt[r])
                     + c_SW'(issA == ADDR_W'(r)) + c_SW'(issB == ADDR_W'(r))
                     - c_SW'(dstA == ADDR_W'(r)) - c_SW'(dstB == ADDR_W'(r));
            w_unf[r] = w_sum[r][c_SW-1];
            w_ovf[r] = !w_sum[r][c_SW-1] && w_sum[r][CNT_W];
        end
    end

    assign iss_ready_o = ~|w_ovf;
    assign err_o       = r_err;

    always_comb begin
        valA = '0;
        valB = '0;
        hazA = 1'b0;
        hazB = 1'b0;
        for (int r = 0; r < c_NREG; r++) begin
            if (srcA == ADDR_W'(r)) begin
                valA = r_mem[r];
`ifdef REGFILE_BYPASS_EN
                hazA = (w_sum[r] != '0) && !w_unf[r];
`else
                hazA = (r_cnt[r] != '0);
`endif
            end
            if (srcB == ADDR_W'(r)) begin
                valB = r_mem[r];
`ifdef REGFILE_BYPASS_EN
                hazB = (w_sum[r] != '0) && !w_unf[r];
`else
                hazB = (r_cnt[r] != '0);
`endif
            end
        end
`ifdef REGFILE_BYPASS_EN
        // Port B wins over port A, matching the write priority.
        if (srcA != c_RNONE) begin
            if (srcA == dstB)      valA = dstB_data;
            else if (srcA == dstA) valA = dstA_data;
        end
        if (srcB != c_RNONE) begin
            if (srcB == dstB)      valB = dstB_data;
            else if (srcB == dstA) valB = dstA_data;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < c_NREG; r++) begin
                r_mem[r] <= '0;
                r_cnt[r] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int r = 0; r < c_NREG; r++) begin
                if (w_unf[r])       r_cnt[r] <= '0;
                else if (!w_ovf[r]) r_cnt[r] <= w_sum[r][CNT_W-1:0];
                if (dstB == ADDR_W'(r))      r_mem[r] <= dstB_data;
                else if (dstA == ADDR_W'(r)) r_mem[r] <= dstA_data;
            end
            if ((|w_ovf) || (|w_unf)) r_err <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_regfile_scb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scb
// Purpose  : Self-checking bench for regfile_scb against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scb;
    localparam int         NREG = 15;
    localparam int         MAXC = 3;
    localparam logic [3:0] RN   = 4'hF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  srcA, srcB, dstA, dstB, issA, issB;
    logic [63:0] valA, valB, dstA_data, dstB_data;
    logic        hazA, hazB, issReady, errO;

    always #5 clk_i = ~clk_i;

    regfile_scb #(.DATA_W(64), .ADDR_W(4), .CNT_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .hazA(hazA), .hazB(hazB),
        .dstA(dstA), .dstB(dstB), .dstA_data(dstA_data), .dstB_data(dstB_data),
        .issA(issA), .issB(issB), .iss_ready_o(issReady), .err_o(errO)
    );

    logic [63:0] mMem [NREG];
    int          mCnt [NREG];
    logic        mErr;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nextCnt(input int r);
        int n;
        n = mCnt[r];
        if (issA == 4'(r)) n++;
        if (issB == 4'(r)) n++;
        if (dstA == 4'(r)) n--;
        if (dstB == 4'(r)) n--;
        return n;
    endfunction

    function automatic logic [63:0] expVal(input logic [3:0] s);
        if (s == RN) return '0;
`ifdef REGFILE_BYPASS_EN
        if (s == dstB) return dstB_data;
        if (s == dstA) return dstA_data;
`endif
        return mMem[s];
    endfunction

    function automatic logic expHaz(input logic [3:0] s);
        if (s == RN) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        return nextCnt(int'(s)) > 0;
`else
        return mCnt[s] != 0;
`endif
    endfunction

    function automatic logic expReady();
        logic ok;
        ok = 1'b1;
        if (issA != RN && nextCnt(int'(issA)) > MAXC) ok = 1'b0;
        if (issB != RN && nextCnt(int'(issB)) > MAXC) ok = 1'b0;
        return ok;
    endfunction

    task automatic modelEdge();
        int n;
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                mMem[r] = '0;
                mCnt[r] = 0;
            end
            mErr = 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                n = nextCnt(r);
                if ((issA == 4'(r) || issB == 4'(r)) && n > MAXC) mErr = 1'b1;
                else if (n < 0) begin
                    mCnt[r] = 0;
                    mErr    = 1'b1;
                end else mCnt[r] = n;
            end
            if (dstA != RN) mMem[dstA] = dstA_data;
            if (dstB != RN) mMem[dstB] = dstB_data;
        end
    endtask

    task automatic idle();
        rst_i = 1'b0;
        srcA = RN; srcB = RN; dstA = RN; dstB = RN; issA = RN; issB = RN;
        dstA_data = '0; dstB_data = '0;
    endtask

    // Check every output mid-cycle, then clock and advance the model.
    task automatic step();
        @(negedge clk_i);
        chk("valA", valA, expVal(srcA));
        chk("valB", valB, expVal(srcB));
        chk("hazA", 64'(hazA), 64'(expHaz(srcA)));
        chk("hazB", 64'(hazB), 64'(expHaz(srcB)));
        chk("ready", 64'(issReady), 64'(expReady()));
        chk("err", 64'(errO), 64'(mErr));
        @(posedge clk_i);
        modelEdge();
        #1;
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        @(posedge clk_i);
        modelEdge();
        #1;

        // Reset state across every index
        idle(); rst_i = 1'b1; step();
        for (int s = 0; s < 16; s++) begin
            idle(); srcA = 4'(s); srcB = 4'(15 - s);
            #1;
            chk("rst_val", valA, 64'h0);
            chk("rst_haz", 64'(hazA), 64'h0);
            step();
        end

        // Same-cycle double write-back: port B data kept
        idle(); dstA = 4'd3; dstA_data = 64'h1111; dstB = 4'd3; dstB_data = 64'h2222; step();
        idle(); srcA = 4'd3; #1;
        chk("dual_wb", valA, 64'h2222);
        chk("rnone_val", valB, 64'h0);
        step();

        // Issue then write-back on register 5
        idle(); issA = 4'd5; srcA = 4'd5; step();
        idle(); srcA = 4'd5; #1;
        chk("iss_haz", 64'(hazA), 64'h1);
        dstA = 4'd5; dstA_data = 64'hABCD; #1;
`ifdef REGFILE_BYPASS_EN
        chk("wb_val_cur", valA, 64'hABCD);
        chk("wb_haz_cur", 64'(hazA), 64'h0);
`else
        chk("wb_val_cur", valA, 64'h0);
        chk("wb_haz_cur", 64'(hazA), 64'h1);
`endif
        step();
        idle(); srcA = 4'd5; #1;
        chk("wb_val_next", valA, 64'hABCD);
        chk("wb_haz_next", 64'(hazA), 64'h0);
        step();

        // Counter saturation on register 7
        for (int i = 0; i < 3; i++) begin
            idle(); issA = 4'd7; srcA = 4'd7; step();
        end
        idle(); issA = 4'd7; srcA = 4'd7; #1;
        chk("ovf_ready", 64'(issReady), 64'h0);
        step();
        idle(); srcA = 4'd7; #1;
        chk("ovf_err", 64'(errO), 64'h1);
        for (int i = 0; i < 3; i++) begin
            idle(); srcA = 4'd7; dstA = 4'd7; dstA_data = 64'(i); step();
            idle(); srcA = 4'd7; #1;
            chk("drain_haz", 64'(hazA), (i < 2) ? 64'h1 : 64'h0);
        end

        // Net-zero issue/write-back, then underflow
        idle(); rst_i = 1'b1; step();
        idle(); issA = 4'd2; step();
        idle(); issA = 4'd2; dstA = 4'd2; dstA_data = 64'h77; srcA = 4'd2; step();
        idle(); srcA = 4'd2; #1;
        chk("net_haz", 64'(hazA), 64'h1);
        chk("net_err", 64'(errO), 64'h0);
        idle(); dstA = 4'd9; dstA_data = 64'h55; step();
        idle(); srcA = 4'd9; #1;
        chk("unf_val", valA, 64'h55);
        chk("unf_err", 64'(errO), 64'h1);
        chk("unf_haz", 64'(hazA), 64'h0);
        step();

        // Reset discards pending state and a concurrent write
        idle(); issA = 4'd1; issB = 4'd4; step();
        idle(); rst_i = 1'b1; dstA = 4'd1; dstA_data = 64'hDEAD; step();
        idle(); srcA = 4'd1; srcB = 4'd4; #1;
        chk("rst_mid_val", valA, 64'h0);
        chk("rst_mid_hazA", 64'(hazA), 64'h0);
        chk("rst_mid_hazB", 64'(hazB), 64'h0);
        chk("rst_mid_err", 64'(errO), 64'h0);
        step();

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            idle();
            rst_i = ($urandom_range(0, 29) == 0);
            srcA = 4'($urandom_range(0, 15));
            srcB = 4'($urandom_range(0, 15));
            dstA = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 7)) : RN;
            dstB = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 7)) : RN;
            issA = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 7)) : RN;
            issB = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 7)) : RN;
            dstA_data = {$urandom, $urandom};
            dstB_data = {$urandom, $urandom};
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
